// File: rtl/imem_pkg.sv
// Shared types and helpers for the boot-loaded instruction memory.
// Holds the boot state encoding, the default NOP word and the parity helper.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    // Even-parity bit: the stored word plus this bit always XOR to zero.
    // Narrow operands are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_boot_fetch_if.sv
// Load-port and fetch-port bundle between the IF stage and the instruction memory.
// The master modport belongs to the PC/loader side, the slave modport to the memory.
interface imem_boot_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_par_inv;
    logic              ld_ready;
    logic              boot_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [1:0]        fault;
    logic              parity_err;

    modport master (
        output ld_valid, ld_data, ld_last, ld_par_inv, fetch_req, fetch_addr, stall,
        input  ld_ready, boot_done, instr, instr_valid, fault, parity_err
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, ld_par_inv, fetch_req, fetch_addr, stall,
        output ld_ready, boot_done, instr, instr_valid, fault, parity_err
    );
endinterface

// File: rtl/imem_array.sv
// DEPTH x W storage with one write port and one registered read port.
// The read register resets to RST_WORD so the fetch output starts at a known word.
module imem_array #(
    parameter int           W        = 16,
    parameter int           DEPTH    = 64,
    parameter int           IDX_W    = $clog2(DEPTH),
    parameter logic [W-1:0] RST_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // NOTE: storage has no reset; the CLEAR pass writes every word before any fetch is served.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rdata <= RST_WORD;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_boot_fetch.sv
// Instruction memory with boot sequence: CLEAR to NOP, stream-load a program, then serve fetches.
// Optional feature macro IMEM_PARITY_EN adds a stored even-parity bit per word and parity_err.
module imem_boot_fetch
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_fetch_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef IMEM_PARITY_EN
    localparam int                MEM_W   = DATA_W + 1;
    localparam logic [MEM_W-1:0]  NOP_MEM = {parity_of(64'(NOP_WORD)), NOP_WORD};
`else
    localparam int                MEM_W   = DATA_W;
    localparam logic [MEM_W-1:0]  NOP_MEM = NOP_WORD;
`endif

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_cnt;
    logic [IDX_W-1:0]   r_ld_ptr;
    logic               r_valid;
    logic [1:0]         r_fault;

    logic               w_we;
    logic [IDX_W-1:0]   w_waddr;
    logic [MEM_W-1:0]   w_wdata;
    logic               w_ld_acc;
    logic [MEM_W-1:0]   w_ld_word;
    logic [MEM_W-1:0]   w_rdata;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_misaligned;
    logic               w_range_err;
    logic               w_fetch;

`ifdef IMEM_PARITY_EN
    assign w_ld_word = {parity_of(64'(bus.ld_data)) ^ bus.ld_par_inv, bus.ld_data};
`else
    logic w_unused_par_inv;
    assign w_unused_par_inv = bus.ld_par_inv;
    assign w_ld_word        = bus.ld_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= CLEAR;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_clr_cnt;
        w_wdata     = NOP_MEM;
        w_ld_acc    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_clr_cnt == IDX_W'(DEPTH - 1))
                    w_state_nxt = LOAD;
            end
            LOAD: begin
                w_ld_acc = bus.ld_valid;
                w_we     = bus.ld_valid;
                w_waddr  = r_ld_ptr;
                w_wdata  = w_ld_word;
                // No wrap: the word written at the last index ends loading.
                if (bus.ld_valid && (bus.ld_last || r_ld_ptr == IDX_W'(DEPTH - 1)))
                    w_state_nxt = RUN;
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_cnt <= '0;
            r_ld_ptr  <= '0;
        end else begin
            if (r_state == CLEAR)
                r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_ld_acc)
                r_ld_ptr <= r_ld_ptr + 1'b1;
        end
    end

    assign w_idx        = {1'b0, bus.fetch_addr[ADDR_W-1:1]};
    assign w_misaligned = bus.fetch_addr[0];
    assign w_range_err  = (w_idx >= ADDR_W'(DEPTH));
    assign w_fetch      = (r_state == RUN) && !bus.stall && bus.fetch_req;

    imem_array #(
        .W        (MEM_W),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .RST_WORD (NOP_MEM)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_fetch),
        .i_raddr (w_idx[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Stall freezes everything; an idle unstalled RUN cycle only drops instr_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_fault <= 2'b00;
        end else if (w_fetch) begin
            r_valid <= 1'b1;
            r_fault <= {w_range_err, w_misaligned};
        end else if (r_state == RUN && !bus.stall) begin
            r_valid <= 1'b0;
        end
    end

    // The read register and the fault register update together, so the mux output holds with them.
    assign bus.instr       = (r_fault != 2'b00) ? NOP_WORD : w_rdata[DATA_W-1:0];
    assign bus.instr_valid = r_valid;
    assign bus.fault       = r_fault;
    assign bus.ld_ready    = (r_state == LOAD);
    assign bus.boot_done   = (r_state == RUN);

`ifdef IMEM_PARITY_EN
    assign bus.parity_err = (r_fault == 2'b00) &&
                            (parity_of(64'(w_rdata[DATA_W-1:0])) != w_rdata[DATA_W]);
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Scoreboard bench for imem_boot_fetch: a word-array reference model predicts each fetch,
// and an independent monitor compares whatever the memory presents one cycle later.
module tb_imem_boot_fetch;
    import imem_pkg::*;

    localparam int          DATA_W = 16;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 16;
    localparam logic [15:0] NOP    = 16'h0000;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic [1:0]  fault;
        logic        par;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_boot_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_boot_fetch #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q [$];
    logic [15:0] model_mem [DEPTH];
    bit          model_bad [DEPTH];
    int          model_ptr;
    bit          model_run;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input logic [15:0] addr);
        exp_t e;
        int   idx;
        idx     = int'(addr) >> 1;
        e.fault = {idx >= DEPTH, addr[0]};
        if (e.fault != 2'b00) begin
            e.instr = NOP;
            e.par   = 1'b0;
        end else begin
            e.instr = model_mem[idx];
            e.par   = model_bad[idx];
        end
        return e;
    endfunction

    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.ld_par_inv = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
    endtask

    task automatic reset_and_boot();
        int n;
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = NOP;
            model_bad[i] = 1'b0;
        end
        model_ptr = 0;
        model_run = 1'b0;
        exp_q.delete();
        repeat (2) do_cycle();
        check("rst_instr",       32'(bus.instr), 32'(NOP));
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_fault",       32'(bus.fault), 32'd0);
        check("rst_parity_err",  32'(bus.parity_err), 32'd0);
        check("rst_ld_ready",    32'(bus.ld_ready), 32'd0);
        check("rst_boot_done",   32'(bus.boot_done), 32'd0);
        rst = 1'b1;
        n   = 0;
        while (!bus.ld_ready && n < 200) begin
            do_cycle();
            n++;
        end
        check("boot_clear_cycles", 32'(n), 32'(DEPTH));
    endtask

    task automatic load_word(input logic [15:0] data, input bit last, input bit inv);
        repeat ($urandom_range(0, 2)) begin
            bus.ld_valid = 1'b0;
            bus.ld_data  = 16'($urandom);
            do_cycle();
        end
        bus.ld_valid   = 1'b1;
        bus.ld_data    = data;
        bus.ld_last    = last;
        bus.ld_par_inv = inv;
        check("ld_ready", 32'(bus.ld_ready), 32'(!model_run));
        if (!model_run) begin
            model_mem[model_ptr] = data;
            model_bad[model_ptr] = PAR_EN && inv;
            model_ptr++;
            if (last || model_ptr == DEPTH)
                model_run = 1'b1;
        end
        do_cycle();
        bus.ld_valid   = 1'b0;
        bus.ld_last    = 1'b0;
        bus.ld_par_inv = 1'b0;
        check("boot_done", 32'(bus.boot_done), 32'(model_run));
    endtask

    task automatic fetch(input logic [15:0] addr, input bit stall, input bit req);
        bus.fetch_addr = addr;
        bus.stall      = stall;
        bus.fetch_req  = req;
        if (model_run && !stall && req)
            exp_q.push_back(model_fetch(addr));
        do_cycle();
    endtask

    task automatic random_fetches(input int n);
        for (int i = 0; i < n; i++)
            fetch(16'($urandom_range(0, 16'h9F)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
        fetch(16'h0, 1'b0, 1'b0);
    endtask

    // Monitor: decides from the bus handshake what the memory must present after each edge.
    initial begin
        exp_t h;
        exp_t e;
        bit   hv;
        bit   c_boot, c_stall, c_req;
        h  = '{instr: NOP, fault: 2'b00, par: 1'b0};
        hv = 1'b0;
        forever begin
            @(posedge clk);
            c_boot  = bus.boot_done;
            c_stall = bus.stall;
            c_req   = bus.fetch_req;
            @(negedge clk);
            if (!rst) begin
                h  = '{instr: NOP, fault: 2'b00, par: 1'b0};
                hv = 1'b0;
            end else if (!c_boot) begin
                check("boot_instr_valid", 32'(bus.instr_valid), 32'd0);
                check("boot_instr",       32'(bus.instr), 32'(NOP));
            end else if (c_stall) begin
                check("stall_instr",      32'(bus.instr), 32'(h.instr));
                check("stall_valid",      32'(bus.instr_valid), 32'(hv));
                check("stall_fault",      32'(bus.fault), 32'(h.fault));
                check("stall_parity_err", 32'(bus.parity_err), 32'(h.par));
            end else if (c_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: result presented with no prediction at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_instr",      32'(bus.instr), 32'(e.instr));
                    check("fetch_valid",      32'(bus.instr_valid), 32'd1);
                    check("fetch_fault",      32'(bus.fault), 32'(e.fault));
                    check("fetch_parity_err", 32'(bus.parity_err), 32'(e.par));
                    h  = e;
                    hv = 1'b1;
                end
            end else begin
                check("idle_valid",      32'(bus.instr_valid), 32'd0);
                check("idle_instr_hold", 32'(bus.instr), 32'(h.instr));
                check("idle_fault_hold", 32'(bus.fault), 32'(h.fault));
                hv = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();

        // Boot with an idle load port, fetches ignored outside RUN, then a short program.
        reset_and_boot();
        repeat (3) fetch(16'h0, 1'b0, 1'b1);
        fetch(16'h0, 1'b0, 1'b0);
        repeat (4) do_cycle();
        check("load_idle_boot_done", 32'(bus.boot_done), 32'd0);
        load_word(16'h1010, 1'b0, 1'b0);
        load_word(16'h6002, 1'b0, 1'b1);
        load_word(16'hD004, 1'b1, 1'b0);
        fetch(16'h0000, 1'b0, 1'b1);
        fetch(16'h0002, 1'b0, 1'b1);
        fetch(16'h0004, 1'b0, 1'b1);
        fetch(16'h0010, 1'b0, 1'b1);
        fetch(16'h0006, 1'b0, 1'b1);
        fetch(16'h0000, 1'b0, 1'b0);

        // Stall holds the 6002 result while the address already points at D004.
        fetch(16'h0002, 1'b0, 1'b1);
        repeat (3) fetch(16'h0004, 1'b1, 1'b1);
        fetch(16'h0004, 1'b0, 1'b1);
        fetch(16'h0000, 1'b0, 1'b0);

        // Fault corners, including both bits together and the last valid word.
        fetch(16'h0003, 1'b0, 1'b1);
        fetch(16'h0080, 1'b0, 1'b1);
        fetch(16'h0081, 1'b0, 1'b1);
        fetch(16'hFFFF, 1'b0, 1'b1);
        repeat (2) fetch(16'h0081, 1'b1, 1'b1);
        fetch(16'h007E, 1'b0, 1'b1);
        fetch(16'h0002, 1'b0, 1'b1);
        fetch(16'h0000, 1'b0, 1'b1);
        random_fetches(40);

        // Reset during RUN and again mid-LOAD; the partial program must not survive.
        reset_and_boot();
        for (int i = 0; i < 10; i++)
            load_word(16'($urandom), 1'b0, 1'($urandom));
        rst = 1'b0;
        #1;
        check("midload_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        reset_and_boot();
        load_word(16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            fetch(16'(2 * i), 1'b0, 1'b1);
        fetch(16'h0, 1'b0, 1'b0);

        // Full 64-word program without ld_last; the 65th word is refused.
        reset_and_boot();
        for (int i = 0; i < DEPTH; i++)
            load_word(16'($urandom), 1'b0, $urandom_range(0, 7) == 0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hA5A5;
        check("extra_word_ld_ready", 32'(bus.ld_ready), 32'd0);
        do_cycle();
        bus.ld_valid = 1'b0;
        check("full_boot_done", 32'(bus.boot_done), 32'd1);
        fetch(16'h0000, 1'b0, 1'b1);
        fetch(16'h007E, 1'b0, 1'b1);
        random_fetches(60);

        repeat (3) do_cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
